// File: rtl/fetch_arbiter.sv
// fetch_arbiter: shares one cache-to-memory fetch channel among N_REQ requesters
// (0 = read controller, 1 = write controller) with round-robin arbitration and
// a single fetch outstanding at a time.
//
// Ports:
//   clk, rst_n          clock; rst_n is a synchronous ACTIVE-HIGH reset (1 = reset)
//   req_fetch_req       per-requester request
//   req_fetch_cmd/tag/addr  per-requester payload, requester i in slice i
//   req_fetch_gnt       grant routed to the owner (combinational from m_fetch_gnt)
//   req_fetch_done      done routed to the owner (combinational from m_fetch_done)
//   m_fetch_req         memory-side request, high while in REQ
//   m_fetch_cmd/tag/addr/src  latched payload and owner id
//   m_fetch_gnt/done    memory accept / completion
//   busy                registered state != IDLE
//   timeout_err         sticky watchdog flag, cleared only by reset
module fetch_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LIST_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 1024,
  localparam int unsigned TAG_W     = $clog2(LIST_DEPTH),
  localparam int unsigned SRC_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_fetch_req,
  input  logic [2*N_REQ-1:0]          req_fetch_cmd,
  input  logic [TAG_W*N_REQ-1:0]      req_fetch_tag,
  input  logic [ADDR_WIDTH*N_REQ-1:0] req_fetch_addr,
  output logic [N_REQ-1:0]            req_fetch_gnt,
  output logic [N_REQ-1:0]            req_fetch_done,
  output logic                        m_fetch_req,
  output logic [1:0]                  m_fetch_cmd,
  output logic [TAG_W-1:0]            m_fetch_tag,
  output logic [ADDR_WIDTH-1:0]       m_fetch_addr,
  output logic [SRC_W-1:0]            m_fetch_src,
  input  logic                        m_fetch_gnt,
  input  logic                        m_fetch_done,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  state_t                  state;
  logic [SRC_W-1:0]        rr_ptr;
  logic [SRC_W-1:0]        owner;
  logic [CNT_W-1:0]        wd_cnt;
  logic [SRC_W-1:0]        next_ptr;

  logic                    pick_valid;
  logic [SRC_W-1:0]        pick_idx;
  logic [1:0]              pick_cmd;
  logic [TAG_W-1:0]        pick_tag;
  logic [ADDR_WIDTH-1:0]   pick_addr;

  assign m_fetch_src = owner;
  assign next_ptr    = SRC_W'((32'(owner) + 32'd1) % N_REQ);

  // Round-robin pick: first requester at distance d from rr_ptr, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_cmd   = '0;
    pick_tag   = '0;
    pick_addr  = '0;
    for (int unsigned d = 0; d < N_REQ; d++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!pick_valid && req_fetch_req[i] &&
            ((32'(rr_ptr) + d) % N_REQ) == i) begin
          pick_valid = 1'b1;
          pick_idx   = SRC_W'(i);
          pick_cmd   = req_fetch_cmd[2*i +: 2];
          pick_tag   = req_fetch_tag[TAG_W*i +: TAG_W];
          pick_addr  = req_fetch_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
        end
      end
    end
  end

  // Route memory gnt/done to the owner; events outside their valid state are dropped.
  always_comb begin
    req_fetch_gnt  = '0;
    req_fetch_done = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (SRC_W'(i) == owner) begin
        req_fetch_gnt[i]  = (state == REQ) && m_fetch_gnt;
        req_fetch_done[i] = ((state == REQ) && m_fetch_gnt && m_fetch_done) ||
                            ((state == BUSY) && m_fetch_done);
      end
    end
  end

  // Control FSM with registered payload, flags and watchdog.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      m_fetch_req  <= 1'b0;
      m_fetch_cmd  <= '0;
      m_fetch_tag  <= '0;
      m_fetch_addr <= '0;
      busy         <= 1'b0;
      wd_cnt       <= '0;
      timeout_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state        <= REQ;
            owner        <= pick_idx;
            m_fetch_cmd  <= pick_cmd;
            m_fetch_tag  <= pick_tag;
            m_fetch_addr <= pick_addr;
            m_fetch_req  <= 1'b1;
            busy         <= 1'b1;
          end
        end
        REQ: begin
          if (m_fetch_gnt) begin
            m_fetch_req <= 1'b0;
            if (m_fetch_done) begin
              state  <= IDLE;
              busy   <= 1'b0;
              rr_ptr <= next_ptr;
            end else begin
              state  <= BUSY;
              wd_cnt <= '0;
            end
          end
        end
        BUSY: begin
          // Saturating watchdog; the FSM keeps waiting for done after it fires.
          if (TIMEOUT != 0) begin
            if (32'(wd_cnt) < TIMEOUT) begin
              wd_cnt <= wd_cnt + CNT_W'(1);
            end
            if (32'(wd_cnt) + 32'd1 == TIMEOUT) begin
              timeout_err <= 1'b1;
            end
          end
          if (m_fetch_done) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
          end
        end
        default: begin
          state       <= IDLE;
          m_fetch_req <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_arbiter.sv
// Bench for fetch_arbiter: a table of per-cycle vectors for the single-request
// and pointer-rotation flows, then hand-written contention, reset-in-BUSY and
// watchdog sequences.
module tb_fetch_arbiter;

  localparam logic [31:0] A0 = 32'h1000_0040;
  localparam logic [31:0] A1 = 32'h2000_0080;
  localparam logic [31:0] A2 = 32'h3000_00C0;
  localparam logic [1:0]  N2 = 2'b00;
  localparam logic [1:0]  G0 = 2'b01;
  localparam logic [1:0]  G1 = 2'b10;
  localparam logic [3:0]  P0C = 4'b0001;
  localparam logic [3:0]  P0T = 4'b0011;
  localparam logic [63:0] P0A = {32'h0, A0};
  localparam logic [3:0]  P1C = 4'b1011;
  localparam logic [3:0]  P1T = 4'b0110;
  localparam logic [63:0] P1A = {A1, A2};

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [3:0]  cmd;
  logic [3:0]  tag;
  logic [63:0] addr;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        m_req;
  logic [1:0]  m_cmd;
  logic [1:0]  m_tag;
  logic [31:0] m_addr;
  logic [0:0]  m_src;
  logic        mg;
  logic        md;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  fetch_arbiter #(
    .N_REQ(2), .ADDR_WIDTH(32), .LIST_DEPTH(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_fetch_req(req), .req_fetch_cmd(cmd), .req_fetch_tag(tag), .req_fetch_addr(addr),
    .req_fetch_gnt(gnt), .req_fetch_done(done),
    .m_fetch_req(m_req), .m_fetch_cmd(m_cmd), .m_fetch_tag(m_tag), .m_fetch_addr(m_addr),
    .m_fetch_src(m_src), .m_fetch_gnt(mg), .m_fetch_done(md),
    .busy(busy), .timeout_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [3:0]  cmd;
    logic [3:0]  tag;
    logic [63:0] addr;
    logic        mg;
    logic        md;
    logic [43:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [43:0] ob(input logic r, input logic s, input logic [1:0] c,
                                     input logic [1:0] t, input logic [31:0] a,
                                     input logic [1:0] g, input logic [1:0] d,
                                     input logic b, input logic e);
    return {r, s, c, t, a, g, d, b, e};
  endfunction

  function automatic logic [43:0] obs();
    return {m_req, m_src, m_cmd, m_tag, m_addr, gnt, done, busy, err};
  endfunction

  task automatic add(input logic r, input logic [1:0] q, input logic [3:0] c,
                     input logic [3:0] t, input logic [63:0] a, input logic g,
                     input logic d, input logic [43:0] e);
    vec_t v;
    v.rst = r; v.req = q; v.cmd = c; v.tag = t; v.addr = a;
    v.mg = g; v.md = d; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [0:0] exp_owner;
  logic [1:0] oh;
  int         nreq;

  initial begin
    rst_n = 1'b1; req = '0; cmd = '0; tag = '0; addr = '0; mg = 1'b0; md = 1'b0;
    repeat (2) cyc();

    // Single request (rows 1..10), then pointer rotation and spurious events.
    add(1'b1, G0, P0C, P0T, P0A, 1'b0, 1'b0, ob(1'b0, 1'b0, 2'b00, 2'd0, 32'h0, N2, N2, 1'b0, 1'b0));
    add(1'b0, G0, P0C, P0T, P0A, 1'b0, 1'b0, ob(1'b0, 1'b0, 2'b00, 2'd0, 32'h0, N2, N2, 1'b0, 1'b0));
    add(1'b0, G0, P0C, P0T, P0A, 1'b0, 1'b0, ob(1'b1, 1'b0, 2'b01, 2'd3, A0, N2, N2, 1'b1, 1'b0));
    add(1'b0, G0, P0C, P0T, P0A, 1'b0, 1'b0, ob(1'b1, 1'b0, 2'b01, 2'd3, A0, N2, N2, 1'b1, 1'b0));
    add(1'b0, G0, P0C, P0T, P0A, 1'b1, 1'b0, ob(1'b1, 1'b0, 2'b01, 2'd3, A0, G0, N2, 1'b1, 1'b0));
    add(1'b0, N2, P0C, P0T, P0A, 1'b0, 1'b0, ob(1'b0, 1'b0, 2'b01, 2'd3, A0, N2, N2, 1'b1, 1'b0));
    add(1'b0, N2, P0C, P0T, P0A, 1'b1, 1'b0, ob(1'b0, 1'b0, 2'b01, 2'd3, A0, N2, N2, 1'b1, 1'b0));
    add(1'b0, N2, P0C, P0T, P0A, 1'b0, 1'b0, ob(1'b0, 1'b0, 2'b01, 2'd3, A0, N2, N2, 1'b1, 1'b0));
    add(1'b0, N2, P0C, P0T, P0A, 1'b0, 1'b0, ob(1'b0, 1'b0, 2'b01, 2'd3, A0, N2, N2, 1'b1, 1'b0));
    add(1'b0, N2, P0C, P0T, P0A, 1'b0, 1'b1, ob(1'b0, 1'b0, 2'b01, 2'd3, A0, N2, G0, 1'b1, 1'b0));
    add(1'b0, N2, P0C, P0T, P0A, 1'b0, 1'b0, ob(1'b0, 1'b0, 2'b01, 2'd3, A0, N2, N2, 1'b0, 1'b0));
    add(1'b0, 2'b11, P1C, P1T, P1A, 1'b0, 1'b0, ob(1'b0, 1'b0, 2'b01, 2'd3, A0, N2, N2, 1'b0, 1'b0));
    add(1'b0, G0, P1C, P1T, P1A, 1'b0, 1'b1, ob(1'b1, 1'b1, 2'b10, 2'd1, A1, N2, N2, 1'b1, 1'b0));
    add(1'b0, G0, P1C, P1T, P1A, 1'b1, 1'b1, ob(1'b1, 1'b1, 2'b10, 2'd1, A1, G1, G1, 1'b1, 1'b0));
    add(1'b0, G0, P1C, P1T, P1A, 1'b0, 1'b0, ob(1'b0, 1'b1, 2'b10, 2'd1, A1, N2, N2, 1'b0, 1'b0));
    add(1'b0, G0, P1C, P1T, P1A, 1'b1, 1'b0, ob(1'b1, 1'b0, 2'b11, 2'd2, A2, G0, N2, 1'b1, 1'b0));
    add(1'b0, N2, P1C, P1T, P1A, 1'b0, 1'b1, ob(1'b0, 1'b0, 2'b11, 2'd2, A2, N2, G0, 1'b1, 1'b0));
    add(1'b0, N2, P1C, P1T, P1A, 1'b1, 1'b1, ob(1'b0, 1'b0, 2'b11, 2'd2, A2, N2, N2, 1'b0, 1'b0));
    add(1'b0, N2, P1C, P1T, P1A, 1'b0, 1'b0, ob(1'b0, 1'b0, 2'b11, 2'd2, A2, N2, N2, 1'b0, 1'b0));

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst; req = tbl[i].req; cmd = tbl[i].cmd; tag = tbl[i].tag;
      addr = tbl[i].addr; mg = tbl[i].mg; md = tbl[i].md;
      @(negedge clk);
      chk($sformatf("row%0d", i), 64'(obs()), 64'(tbl[i].exp));
      cyc();
    end

    // Contention from reset: both held, memory grants and completes at once.
    rst_n = 1'b1; req = '0; mg = 1'b0; md = 1'b0;
    cyc();
    rst_n = 1'b0;
    cmd = {2'b10, 2'b01}; tag = {2'b01, 2'b10}; addr = {A1, A0};
    req = 2'b11; mg = 1'b1; md = 1'b1;
    exp_owner = 1'b0;
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_req) begin
        oh = exp_owner ? G1 : G0;
        chk("contend_owner", 64'({m_src, m_tag, gnt, done}),
            64'({exp_owner, (exp_owner ? 2'd1 : 2'd2), oh, oh}));
        nreq++;
        exp_owner = ~exp_owner;
      end
      cyc();
    end
    chk("contend_count", 64'(nreq), 64'(5));

    // Reset during BUSY: owner 1 in flight, pointer already advanced to 1.
    req = '0; mg = 1'b0; md = 1'b0;
    cyc();
    req = G1;
    cyc();
    mg = 1'b1; req = '0;
    @(negedge clk);
    chk("rstbusy_gnt", 64'(gnt), 64'(G1));
    cyc();
    mg = 1'b0;
    @(negedge clk);
    chk("rstbusy_busy", 64'(busy), 64'(1));
    cyc();
    rst_n = 1'b1; req = 2'b11;
    cyc();
    rst_n = 1'b0; req = '0; md = 1'b1;
    @(negedge clk);
    chk("rstbusy_outs", 64'(obs()), 64'(0));
    cyc();
    md = 1'b0; req = 2'b11;
    cyc();
    @(negedge clk);
    chk("rstbusy_rearb", 64'({m_req, m_src, busy}), 64'({1'b1, 1'b0, 1'b1}));
    mg = 1'b1; md = 1'b1; req = '0;
    cyc();
    mg = 1'b0; md = 1'b0;
    cyc();

    // Watchdog: grant given, done withheld.
    req = G0;
    cyc();
    mg = 1'b1; req = '0;
    @(negedge clk);
    chk("wd_gnt", 64'(gnt), 64'(G0));
    cyc();
    mg = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk($sformatf("wd_err_c%0d", k), 64'(err), 64'(k > 16));
      cyc();
    end
    md = 1'b1;
    @(negedge clk);
    chk("wd_late_done", 64'({done, busy, err}), 64'({G0, 1'b1, 1'b1}));
    cyc();
    md = 1'b0;
    @(negedge clk);
    chk("wd_sticky", 64'({busy, err}), 64'({1'b0, 1'b1}));
    cyc();
    rst_n = 1'b1;
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("wd_cleared", 64'(err), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
